fpu_mul_sched: RTL and testbench

Round-robin scheduler that shares one single-precision multiplier (the combinational fpu_mul datapath or a pipelined variant) between NUM_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. The scheduler grants one requester, holds the operands stable on the multiplier inputs for MUL_LAT cycles, captures the product, and returns it with the requester's ID over a valid/ready response channel. It sits between the compute clients and the single shared multiplier instance.

---
 rtl/fpu_mul_sched.sv | 122 ++++++++++++
 tb/tb_fpu_mul_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_sched.sv
// Round-robin scheduler sharing one single-precision multiplier among NUM_REQ
// requesters: grant, hold operands for MUL_LAT cycles, capture, respond.
module fpu_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [3:0]        lat_cnt_reg;
  logic [31:0]       mul_a_reg, mul_b_reg, rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_valid_reg;

  logic [31:0]       a_arr [NUM_REQ];
  logic [31:0]       b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] hi_valid;
  logic [ID_W-1:0]   grant_id;
  logic              grant_hs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]    = req_a[32*gi +: 32];
      assign b_arr[gi]    = req_b[32*gi +: 32];
      // Requesters at or above the pointer take priority over wrapped ones.
      assign hi_valid[gi] = req_valid[gi] & (ID_W'(gi) >= rr_ptr_reg);
      assign req_ready[gi] = (state_reg == IDLE) && !rst && (|req_valid)
                             && (grant_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_id = '0;
    if (|hi_valid) begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (hi_valid[i]) grant_id = ID_W'(i);
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (req_valid[i]) grant_id = ID_W'(i);
    end
  end

  assign grant_hs = |req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_hs) state_next = HOLD;
      HOLD:    if (lat_cnt_reg == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      lat_cnt_reg   <= 4'd0;
      mul_a_reg     <= 32'd0;
      mul_b_reg     <= 32'd0;
      rsp_data_reg  <= 32'd0;
      rsp_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_hs) begin
            mul_a_reg   <= a_arr[grant_id];
            mul_b_reg   <= b_arr[grant_id];
            rsp_id_reg  <= grant_id;
            lat_cnt_reg <= 4'(MUL_LAT - 1);
          end
        end
        HOLD: begin
          if (lat_cnt_reg == 4'd0) begin
            rsp_data_reg  <= mul_result;
            rsp_valid_reg <= 1'b1;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= (rsp_id_reg == ID_W'(NUM_REQ - 1)) ? '0
                                                                 : rsp_id_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Bench for fpu_mul_sched: table vectors, throughput/backpressure/latency/reset
// sequences, and randomized ops checked against a round-robin reference model.
module tb_fpu_mul_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with MUL_LAT=1 and a combinational multiplier model.
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_result, rsp_data;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;

  // Instance with MUL_LAT=3 and a two-stage registered multiplier model.
  logic [3:0]   req_valid3, req_ready3;
  logic [127:0] req_a3, req_b3;
  logic [31:0]  mul_a3, mul_b3, mul_result3, rsp_data3;
  logic         rsp_valid3, rsp_ready3, busy3;
  logic [1:0]   rsp_id3;
  logic [31:0]  stage1, stage2;

  int checks = 0;
  int failures = 0;
  int model_rr = 0;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    ex = 8'($urandom_range(100, 150));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  function automatic logic [127:0] rand_bus();
    return {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
  endfunction

  function automatic int model_pick(input logic [3:0] v, input int rr);
    for (int k = 0; k < 4; k++)
      if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] slot(input logic [127:0] bus, input int i);
    return bus[32*i +: 32];
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  always_ff @(posedge clk) begin
    stage1 <= fmul(mul_a3, mul_b3);
    stage2 <= stage1;
  end
  assign mul_result3 = stage2;

  fpu_mul_sched #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  fpu_mul_sched #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_result(mul_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation on the MUL_LAT=1 instance with an optional response stall.
  task automatic do_op(input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                       input int exp_id, input logic [31:0] exp_data, input int stall);
    int n;
    @(posedge clk); #1;
    req_valid = v; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(negedge clk);
    check("grant", 32'(req_ready), 32'(1 << exp_id));
    @(posedge clk); #1;
    req_valid = 4'd0; req_a = ~a; req_b = ~b;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rsp_data", rsp_data, exp_data);
    req_valid = 4'hF;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, exp_data);
      check("stall_id", 32'(rsp_id), 32'(exp_id));
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 4'd0;
    @(negedge clk);
    check("idle_after_rsp", {30'd0, busy, rsp_valid}, 32'd0);
    $display("op valid=%b id=%0d data=%h stall=%0d", v, exp_id, exp_data, stall);
  endtask

  // One operation on the MUL_LAT=3 instance, single requester.
  task automatic op3(input int id, input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ba, bb;
    ba = rand_bus(); bb = rand_bus();
    ba[32*id +: 32] = a; bb[32*id +: 32] = b;
    @(posedge clk); #1;
    req_valid3 = 4'(1 << id); req_a3 = ba; req_b3 = bb; rsp_ready3 = 1'b1;
    @(negedge clk);
    check("lat3_grant", 32'(req_ready3), 32'(1 << id));
    @(posedge clk); #1;
    req_valid3 = 4'd0; req_a3 = rand_bus(); req_b3 = rand_bus();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lat3_mul_a", mul_a3, a);
      check("lat3_mul_b", mul_b3, b);
      check("lat3_early", 32'(rsp_valid3), 32'd0);
    end
    @(negedge clk);
    check("lat3_valid", 32'(rsp_valid3), 32'd1);
    check("lat3_data", rsp_data3, fmul(a, b));
    check("lat3_id", 32'(rsp_id3), 32'(id));
    @(negedge clk);
    check("lat3_idle", 32'(busy3), 32'd0);
    $display("op3 id=%0d data=%h", id, fmul(a, b));
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_id;
    logic [31:0] exp_data;
    int          stall;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] tv[10] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                         4'b1000, 4'b0101, 4'b0101, 4'b0010, 4'b0011};
  int te[10] = '{0, 1, 2, 3, 0, 3, 0, 2, 1, 0};
  int ts[10] = '{0, 0, 0, 5, 0, 0, 2, 0, 0, 0};

  initial begin
    logic [127:0] ba, bb;
    int gcyc[$];
    int gid[$];
    int exp_ids[4] = '{1, 2, 3, 0};
    int last_id;

    req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid3 = 4'd0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;

    // Reset state while requests are pending.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst = 1'b0; req_valid = 4'd0;

    tbl[0] = '{4'b0001, 32'h40000000, 32'h40400000, 0, 32'h40C00000, 0};
    for (int i = 1; i < 10; i++) begin
      logic [31:0] a, b;
      a = rand_fp(); b = rand_fp();
      tbl[i] = '{tv[i], a, b, te[i], fmul(a, b), ts[i]};
    end
    for (int i = 0; i < 10; i++) begin
      ba = rand_bus(); bb = rand_bus();
      ba[32*tbl[i].exp_id +: 32] = tbl[i].a;
      bb[32*tbl[i].exp_id +: 32] = tbl[i].b;
      do_op(tbl[i].valid, ba, bb, tbl[i].exp_id, tbl[i].exp_data, tbl[i].stall);
    end

    // All requesters valid with rsp_ready held high: grant order and spacing.
    ba = rand_bus(); bb = rand_bus();
    last_id = -1;
    @(posedge clk); #1;
    req_valid = 4'hF; req_a = ba; req_b = bb; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("tp_rsp_id", 32'(rsp_id), 32'(last_id));
        check("tp_rsp_data", rsp_data, fmul(slot(ba, last_id), slot(bb, last_id)));
      end
      for (int k = 0; k < 4; k++)
        if (req_ready[k]) begin
          gcyc.push_back(c); gid.push_back(k); last_id = k;
          $display("tp grant id=%0d cycle=%0d", k, c);
        end
    end
    req_valid = 4'd0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("tp_count", 32'(gid.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < gid.size()) begin
        check("tp_order", 32'(gid[k]), 32'(exp_ids[k]));
        check("tp_spacing", 32'(gcyc[k]), 32'(3 * k));
      end
    model_rr = 1;

    // Randomized operations against the round-robin reference model.
    for (int r = 0; r < 40; r++) begin
      logic [3:0] v;
      int e;
      if (r % 7 == 3) begin
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
      v = 4'($urandom_range(1, 15));
      e = model_pick(v, model_rr);
      ba = rand_bus(); bb = rand_bus();
      do_op(v, ba, bb, e, fmul(slot(ba, e), slot(bb, e)), int'($urandom_range(0, 3)));
      model_rr = (e + 1) % 4;
    end

    // MUL_LAT=3: operands held three cycles, fresh product captured.
    op3(1, 32'h40000000, 32'h40400000);
    op3(2, 32'h3FC00000, 32'hC0800000);
    op3(0, rand_fp(), rand_fp());

    // Reset asserted while an operation is in HOLD.
    ba = rand_bus(); bb = rand_bus();
    @(posedge clk); #1;
    req_valid = 4'b0010; req_a = ba; req_b = bb; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mul_a", mul_a, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0; req_valid = 4'd0; rsp_ready = 1'b0;
    ba = rand_bus(); bb = rand_bus();
    do_op(4'b1001, ba, bb, 0, fmul(slot(ba, 0), slot(bb, 0)), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
